// File: rtl/servo_pkg.sv
// Shared pulse type, default timing and reset widths for the servo PWM path.
// The reset widths are also consumed by the inverse-kinematics lookup.
package servo_pkg;

  typedef logic [23:0] pulse_t;

  localparam int unsigned FRAME_CYCLES_DEF = 2000000;
  localparam int unsigned MIN_PULSE_DEF    = 50000;
  localparam int unsigned MAX_PULSE_DEF    = 250000;
  localparam int unsigned SLEW_STEP_DEF    = 4000;
  localparam int unsigned SHOULDER_RST_DEF = 180000;
  localparam int unsigned ELBOW_RST_DEF    = 145000;

  function automatic pulse_t clamp_pulse(input pulse_t target, input pulse_t lo, input pulse_t hi);
    pulse_t r;
    r = target;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo output: clamps the requested width, slews the active width at
// frame boundaries and produces the registered PWM pulse.
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned MIN_PULSE = MIN_PULSE_DEF,
  parameter int unsigned MAX_PULSE = MAX_PULSE_DEF,
  parameter int unsigned SLEW_STEP = SLEW_STEP_DEF,
  parameter int unsigned RST_PULSE = SHOULDER_RST_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         update_i,
  input  logic         pwm_en_i,
  input  logic [23:0]  frame_cnt_i,
  input  logic [23:0]  target_i,
  output logic         pwm_o,
  output logic         at_target_o
);

  localparam pulse_t      MIN_P  = pulse_t'(MIN_PULSE);
  localparam pulse_t      MAX_P  = pulse_t'(MAX_PULSE);
  localparam pulse_t      RST_P  = pulse_t'(RST_PULSE);
  localparam pulse_t      STEP_P = pulse_t'(SLEW_STEP);
  localparam logic [24:0] STEP_W = 25'(SLEW_STEP);

  pulse_t             clamped;
  logic signed [24:0] diff;
  logic [24:0]        diff_mag;
  pulse_t             active_q, active_d;
  logic               pwm_q, pwm_d;

  always_comb begin
    clamped  = clamp_pulse(target_i, MIN_P, MAX_P);
    diff     = $signed({1'b0, clamped}) - $signed({1'b0, active_q});
    diff_mag = diff[24] ? $unsigned(-diff) : $unsigned(diff);

    active_d = active_q;
    if (update_i) begin
      if ((SLEW_STEP == 0) || (diff_mag <= STEP_W)) begin
        active_d = clamped;
      end else if (diff[24]) begin
        active_d = active_q - STEP_P;
      end else begin
        active_d = active_q + STEP_P;
      end
    end

    // Compare uses the width in force this frame, so the pulse is never cut or stretched.
    pwm_d = pwm_en_i && (frame_cnt_i < active_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= RST_P;
      pwm_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o       = pwm_q;
  assign at_target_o = (active_q == clamped);

endmodule

// File: rtl/servo_pwm_driver.sv
// Dual-channel servo PWM generator: shared frame counter, per-frame enable
// arming and the two shoulder/elbow channels.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned MIN_PULSE    = MIN_PULSE_DEF,
  parameter int unsigned MAX_PULSE    = MAX_PULSE_DEF,
  parameter int unsigned SLEW_STEP    = SLEW_STEP_DEF,
  parameter int unsigned SHOULDER_RST = SHOULDER_RST_DEF,
  parameter int unsigned ELBOW_RST    = ELBOW_RST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [23:0] shoulder_target,
  input  logic [23:0] elbow_target,
  output logic        shoulder_pwm,
  output logic        elbow_pwm,
  output logic        frame_start,
  output logic        settled
);

  localparam int               CNT_W    = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             armed_q, armed_d;
  logic             wrap;
  logic             update;
  logic             pwm_en;
  pulse_t           frame_cnt_ext;
  logic             sh_at_target, el_at_target;

  assign wrap          = (frame_cnt_q == CNT_LAST);
  assign update        = wrap && enable;
  assign pwm_en        = enable && armed_q;
  assign frame_cnt_ext = pulse_t'(frame_cnt_q);

  always_comb begin
    frame_cnt_d = wrap ? '0 : frame_cnt_q + CNT_W'(1);
    // A disable anywhere in a frame blanks the rest of it; re-armed at the wrap.
    if (wrap) begin
      armed_d = 1'b1;
    end else if (!enable) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      armed_q     <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      armed_q     <= armed_d;
    end
  end

  servo_channel #(
    .MIN_PULSE (MIN_PULSE),
    .MAX_PULSE (MAX_PULSE),
    .SLEW_STEP (SLEW_STEP),
    .RST_PULSE (SHOULDER_RST)
  ) u_shoulder (
    .clk         (clk),
    .reset       (reset),
    .update_i    (update),
    .pwm_en_i    (pwm_en),
    .frame_cnt_i (frame_cnt_ext),
    .target_i    (shoulder_target),
    .pwm_o       (shoulder_pwm),
    .at_target_o (sh_at_target)
  );

  servo_channel #(
    .MIN_PULSE (MIN_PULSE),
    .MAX_PULSE (MAX_PULSE),
    .SLEW_STEP (SLEW_STEP),
    .RST_PULSE (ELBOW_RST)
  ) u_elbow (
    .clk         (clk),
    .reset       (reset),
    .update_i    (update),
    .pwm_en_i    (pwm_en),
    .frame_cnt_i (frame_cnt_ext),
    .target_i    (elbow_target),
    .pwm_o       (elbow_pwm),
    .at_target_o (el_at_target)
  );

  assign frame_start = (frame_cnt_q == '0);
  assign settled     = sh_at_target && el_at_target;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Frame-level bench for servo_pwm_driver: measures each frame's pulse widths
// and compares them with constant vectors and a per-frame width model.
module tb_servo_pwm_driver;

  localparam int FC     = 1000;
  localparam int MINP   = 50;
  localparam int MAXP   = 250;
  localparam int SLEW   = 40;
  localparam int SH_RST = 180;
  localparam int EL_RST = 145;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [23:0] shoulder_target;
  logic [23:0] elbow_target;
  logic        shoulder_pwm;
  logic        elbow_pwm;
  logic        frame_start;
  logic        settled;

  int total = 0;
  int bad   = 0;
  int m_sh, m_el;

  typedef struct {
    logic [23:0] sh_t;
    logic [23:0] el_t;
    int          e_sh;
    int          e_el;
    bit          e_st;
  } vec_t;

  vec_t vecs[13];

  servo_pwm_driver #(
    .FRAME_CYCLES (FC),
    .MIN_PULSE    (MINP),
    .MAX_PULSE    (MAXP),
    .SLEW_STEP    (SLEW),
    .SHOULDER_RST (SH_RST),
    .ELBOW_RST    (EL_RST)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .shoulder_target (shoulder_target),
    .elbow_target    (elbow_target),
    .shoulder_pwm    (shoulder_pwm),
    .elbow_pwm       (elbow_pwm),
    .frame_start     (frame_start),
    .settled         (settled)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic int clampw(input logic [23:0] t);
    int v;
    v = int'(t);
    if (v < MINP) v = MINP;
    if (v > MAXP) v = MAXP;
    return v;
  endfunction

  // Width one frame later: jump if within one slew step, otherwise move one step.
  function automatic int stepw(input int a, input int c);
    if ((c - a <= SLEW) && (a - c <= SLEW)) return c;
    if (c > a) return a + SLEW;
    return a - SLEW;
  endfunction

  function automatic int exp_w(input int m, input int dis_from);
    if (dis_from > 0 && dis_from < m) return dis_from;
    return m;
  endfunction

  function automatic bit exp_st();
    return (m_sh == clampw(shoulder_target)) && (m_el == clampw(elbow_target));
  endfunction

  function automatic logic [23:0] rnd_t();
    if ($urandom_range(0, 5) == 0) return 24'($urandom());
    return 24'($urandom_range(0, 320));
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Starts on the falling edge where frame_cnt == 0 and ends on the next one.
  task automatic run_frame(input logic [23:0] sh_t, input logic [23:0] el_t,
                           input int chg_at, input logic [23:0] sh2, input logic [23:0] el2,
                           input int dis_from, input int dis_to,
                           output int w_sh, output int w_el, output bit shape_ok,
                           output bit st, output bit en_wrap);
    shape_ok        = (frame_start === 1'b1);
    st              = (settled === 1'b1);
    shoulder_target = sh_t;
    elbow_target    = el_t;
    enable          = 1'b1;
    w_sh            = 0;
    w_el            = 0;
    en_wrap         = 1'b1;
    for (int j = 1; j <= FC; j++) begin
      @(negedge clk);
      if (shoulder_pwm === 1'b1) begin
        if (j != w_sh + 1) shape_ok = 1'b0;
        w_sh++;
      end
      if (elbow_pwm === 1'b1) begin
        if (j != w_el + 1) shape_ok = 1'b0;
        w_el++;
      end
      if (frame_start !== (j == FC)) shape_ok = 1'b0;
      if (j == chg_at) begin
        shoulder_target = sh2;
        elbow_target    = el2;
      end
      if (j == dis_from) enable = 1'b0;
      if (j == dis_to) enable = 1'b1;
      if (j == FC - 1) en_wrap = enable;
    end
  endtask

  task automatic frame_chk(input string nm, input logic [23:0] sh_t, input logic [23:0] el_t,
                           input int chg_at, input logic [23:0] sh2, input logic [23:0] el2,
                           input int dis_from, input int dis_to,
                           input int e_sh, input int e_el, input bit e_st);
    int w_sh, w_el;
    bit ok, st, enw;
    run_frame(sh_t, el_t, chg_at, sh2, el2, dis_from, dis_to, w_sh, w_el, ok, st, enw);
    check({nm, " shoulder_width"}, w_sh, e_sh);
    check({nm, " elbow_width"}, w_el, e_el);
    check({nm, " settled"}, int'(st), int'(e_st));
    check({nm, " pulse_shape"}, int'(ok), 1);
    if (enw) begin
      m_sh = stepw(m_sh, clampw(shoulder_target));
      m_el = stepw(m_el, clampw(elbow_target));
    end
  endtask

  task automatic model_frame(input string nm, input logic [23:0] sh_t, input logic [23:0] el_t,
                             input int chg_at, input logic [23:0] sh2, input logic [23:0] el2,
                             input int dis_from, input int dis_to);
    frame_chk(nm, sh_t, el_t, chg_at, sh2, el2, dis_from, dis_to,
              exp_w(m_sh, dis_from), exp_w(m_el, dis_from), exp_st());
  endtask

  initial begin
    reset           = 1'b1;
    enable          = 1'b1;
    shoulder_target = 24'd180;
    elbow_target    = 24'd145;
    m_sh            = SH_RST;
    m_el            = EL_RST;

    vecs[0]  = '{24'd180, 24'd145,      180, 145, 1'b1};
    vecs[1]  = '{24'd250, 24'd145,      180, 145, 1'b1};
    vecs[2]  = '{24'd250, 24'd145,      220, 145, 1'b0};
    vecs[3]  = '{24'd250, 24'd10,       250, 145, 1'b1};
    vecs[4]  = '{24'd250, 24'd10,       250, 105, 1'b0};
    vecs[5]  = '{24'd250, 24'd10,       250, 65,  1'b0};
    vecs[6]  = '{24'd250, 24'hFFFFFF,   250, 50,  1'b1};
    vecs[7]  = '{24'd250, 24'hFFFFFF,   250, 90,  1'b0};
    vecs[8]  = '{24'd250, 24'hFFFFFF,   250, 130, 1'b0};
    vecs[9]  = '{24'd250, 24'hFFFFFF,   250, 170, 1'b0};
    vecs[10] = '{24'd250, 24'hFFFFFF,   250, 210, 1'b0};
    vecs[11] = '{24'd250, 24'hFFFFFF,   250, 250, 1'b1};
    vecs[12] = '{24'd250, 24'hFFFFFF,   250, 250, 1'b1};

    repeat (3) @(negedge clk);
    check("reset shoulder_pwm", int'(shoulder_pwm), 0);
    check("reset elbow_pwm", int'(elbow_pwm), 0);
    check("reset frame_start", int'(frame_start), 1);
    check("reset settled", int'(settled), 1);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      frame_chk($sformatf("vec%0d", i), vecs[i].sh_t, vecs[i].el_t, 0, 24'd0, 24'd0, 0, 0,
                vecs[i].e_sh, vecs[i].e_el, vecs[i].e_st);
    end

    model_frame("midchg_a", 24'd250, 24'hFFFFFF, 500, 24'd140, 24'd60, 0, 0);
    model_frame("midchg_b", 24'd140, 24'd60, 0, 24'd0, 24'd0, 0, 0);
    model_frame("endrop_a", 24'd170, 24'd170, 0, 24'd0, 24'd0, 20, 100);
    model_frame("endrop_b", 24'd170, 24'd170, 0, 24'd0, 24'd0, 0, 0);
    model_frame("wrapoff_a", 24'd100, 24'd170, 0, 24'd0, 24'd0, 990, 0);
    model_frame("wrapoff_b", 24'd100, 24'd170, 0, 24'd0, 24'd0, 0, 0);
    model_frame("wrapoff_c", 24'd100, 24'd170, 0, 24'd0, 24'd0, 0, 0);

    shoulder_target = 24'd250;
    elbow_target    = 24'd250;
    enable          = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_mid pwm_before", int'(shoulder_pwm), 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid shoulder_pwm", int'(shoulder_pwm), 0);
    check("rst_mid elbow_pwm", int'(elbow_pwm), 0);
    check("rst_mid frame_start", int'(frame_start), 1);
    reset = 1'b0;
    m_sh  = SH_RST;
    m_el  = EL_RST;
    model_frame("rst_after", 24'd250, 24'd250, 0, 24'd0, 24'd0, 0, 0);
    model_frame("rst_next", 24'd250, 24'd250, 0, 24'd0, 24'd0, 0, 0);

    for (int k = 0; k < 12; k++) begin
      model_frame($sformatf("rand%0d", k), rnd_t(), rnd_t(), 0, 24'd0, 24'd0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
